// File: rtl/key_pulse.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | key_pulse : push-button debouncer with one-cycle press/auto-repeat pulses |
// | Revision  : 1.0                                                           |
// +---------------------------------------------------------------------------+
module key_pulse #(
   parameter int ACTIVE_LOW   = 1,
   parameter int STABLE_CNT   = 500000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 10000000,
   parameter int CNT_WIDTH    = 25
) (
   input  logic CLK,
   input  logic RST,
   input  logic key,
   input  logic repeat_en,
   output logic pressed,
   output logic transition
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   localparam logic                 RELEASED_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CNT - 1);
   localparam logic [CNT_WIDTH-1:0] DELAY_LAST   = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] RATE_LAST    = CNT_WIDTH'(REPEAT_RATE - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 pressed_q, pressed_d;
   logic                 transition_q, transition_d;
   logic [CNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
   state_t               state_q, state_d;

   logic                 key_s;
   logic                 press_rise;
   logic                 press_fall;
   logic [CNT_WIDTH-1:0] rep_last;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q      <= RELEASED_LVL;
         sync2_q      <= RELEASED_LVL;
         pressed_q    <= 1'b0;
         transition_q <= 1'b0;
         deb_cnt_q    <= '0;
         rep_cnt_q    <= '0;
         state_q      <= IDLE;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         pressed_q    <= pressed_d;
         transition_q <= transition_d;
         deb_cnt_q    <= deb_cnt_d;
         rep_cnt_q    <= rep_cnt_d;
         state_q      <= state_d;
      end
   end

   // Synchronizer and debounce: pressed only follows key_s after a full stable run.
   always_comb begin
      sync1_d   = key;
      sync2_d   = sync1_q;
      key_s     = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
      pressed_d = pressed_q;
      deb_cnt_d = '0;
      if (key_s != pressed_q) begin
         if (deb_cnt_q == STABLE_LAST) begin
            pressed_d = key_s;
         end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
         end
      end
   end

   // Edges are taken from pressed_d so the press pulse lands on the same edge as pressed.
   always_comb begin
      state_d      = state_q;
      rep_cnt_d    = rep_cnt_q;
      transition_d = 1'b0;
      press_rise   = pressed_d & ~pressed_q;
      press_fall   = ~pressed_d & pressed_q;
      rep_last     = (state_q == HOLD) ? DELAY_LAST : RATE_LAST;

      case (state_q)
         IDLE: begin
            rep_cnt_d = '0;
            if (press_rise) begin
               state_d      = HOLD;
               transition_d = 1'b1;
            end
         end
         HOLD, REPEAT: begin
            if (press_fall) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (!repeat_en) begin
               rep_cnt_d = '0;
            end else if (rep_cnt_q == rep_last) begin
               // A due pulse right after another one waits a cycle to keep pulses distinct.
               if (!transition_q) begin
                  transition_d = 1'b1;
                  rep_cnt_d    = '0;
                  state_d      = REPEAT;
               end
            end else begin
               rep_cnt_d = rep_cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d   = IDLE;
            rep_cnt_d = '0;
         end
      endcase
   end

   assign pressed    = pressed_q;
   assign transition = transition_q;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_key_pulse : directed vector bench for key_pulse                        |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
module tb_key_pulse;

   localparam int CYCLE = 100;

   logic CLK       = 1'b0;
   logic RST       = 1'b0;
   logic key       = 1'b1;
   logic repeat_en = 1'b0;
   logic pressed;
   logic transition;
   logic toggle    = 1'b0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic k;
      logic ren;
      logic exp_p;
      logic exp_t;
   } vec_t;

   vec_t vecs[$];

   always #(CYCLE/2) CLK = ~CLK;

   // Stand-in for the downstream toggle stage.
   always @(posedge CLK) if (transition === 1'b1) toggle <= ~toggle;

   key_pulse #(
      .ACTIVE_LOW  (1),
      .STABLE_CNT  (4),
      .REPEAT_DELAY(10),
      .REPEAT_RATE (5),
      .CNT_WIDTH   (25)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .key       (key),
      .repeat_en (repeat_en),
      .pressed   (pressed),
      .transition(transition)
   );

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic add_run(input int n, input logic k, input logic ren,
                          input logic p, input logic t);
      vec_t v;
      v.k = k; v.ren = ren; v.exp_p = p; v.exp_t = t;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   // Key pressed from offset 0, released (raw) at rel_raw, repeat enabled throughout.
   // Press pulse at +5, repeats at +15 then every 5, debounced release at rel_raw+5.
   task automatic run_press(input int n, input int rel_raw, input string tag,
                            output int npulse);
      logic exp_p, exp_t;
      npulse = 0;
      for (int off = 0; off < n; off++) begin
         key       = (off < rel_raw) ? 1'b0 : 1'b1;
         repeat_en = 1'b1;
         step();
         exp_p = (off >= 5) && (off < rel_raw + 5);
         exp_t = exp_p && ((off == 5) || ((off >= 15) && ((off - 15) % 5 == 0)));
         check($sformatf("%s pressed off=%0d", tag, off), pressed, exp_p);
         check($sformatf("%s transition off=%0d", tag, off), transition, exp_t);
         if (transition === 1'b1) npulse++;
      end
   endtask

   initial begin
      int n;
      int exp_pulses;
      exp_pulses = 0;

      // Clean press held 20 raw cycles, then release.
      add_run(5,  1'b0, 1'b0, 1'b0, 1'b0);
      add_run(1,  1'b0, 1'b0, 1'b1, 1'b1);
      add_run(14, 1'b0, 1'b0, 1'b1, 1'b0);
      add_run(5,  1'b1, 1'b0, 1'b1, 1'b0);
      add_run(3,  1'b1, 1'b0, 1'b0, 1'b0);
      // Bounce 0,1,0,0,1,0 then steady 0; pulse 5 edges after the final run starts.
      add_run(1,  1'b0, 1'b0, 1'b0, 1'b0);
      add_run(1,  1'b1, 1'b0, 1'b0, 1'b0);
      add_run(2,  1'b0, 1'b0, 1'b0, 1'b0);
      add_run(1,  1'b1, 1'b0, 1'b0, 1'b0);
      add_run(5,  1'b0, 1'b0, 1'b0, 1'b0);
      add_run(1,  1'b0, 1'b0, 1'b1, 1'b1);
      add_run(4,  1'b0, 1'b0, 1'b1, 1'b0);
      add_run(5,  1'b1, 1'b0, 1'b1, 1'b0);
      add_run(2,  1'b1, 1'b0, 1'b0, 1'b0);
      exp_pulses += 2;

      #10 RST = 1'b1;
      #1;
      check("reset pressed immediate", pressed, 1'b0);
      check("reset transition immediate", transition, 1'b0);
      @(posedge CLK);
      #1;
      check("reset pressed held", pressed, 1'b0);
      check("reset transition held", transition, 1'b0);
      #58 RST = 1'b0;
      step();
      check("post reset pressed", pressed, 1'b0);
      check("post reset transition", transition, 1'b0);

      foreach (vecs[i]) begin
         key       = vecs[i].k;
         repeat_en = vecs[i].ren;
         step();
         check($sformatf("vec%0d pressed", i), pressed, vecs[i].exp_p);
         check($sformatf("vec%0d transition", i), transition, vecs[i].exp_t);
      end

      run_press(56, 47, "repeat", n);
      check_int("repeat pulse count", n, 9);
      exp_pulses += 9;

      run_press(61, 45, "collide", n);
      check_int("collide pulse count", n, 8);
      exp_pulses += 8;

      run_press(18, 1000, "prehold", n);
      check_int("prehold pulse count", n, 2);
      exp_pulses += 2;

      RST = 1'b1;
      #1;
      check("midhold reset pressed", pressed, 1'b0);
      check("midhold reset transition", transition, 1'b0);
      step();
      check("midhold reset pressed held", pressed, 1'b0);
      RST = 1'b0;

      run_press(27, 1000, "postrst", n);
      check_int("postrst pulse count", n, 4);
      exp_pulses += 4;

      key       = 1'b1;
      repeat_en = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("final pressed", pressed, 1'b0);
      check("toggle parity", toggle, 1'((exp_pulses % 2) != 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
